// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the alu_pipe ALU: opcode encoding, control
// states and the opcode-validity decode used at the acceptance point.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_RS6 = 3'b110,
        OP_RS7 = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MBUSY = 1'b1
    } state_e;

    // True for opcodes that start real work; NOP and reserved codes are dropped.
    function automatic logic is_valid_op(input logic [2:0] op_v);
        logic valid_v;
        case (op_v)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: valid_v = 1'b1;
            default:                                 valid_v = 1'b0;
        endcase
        return valid_v;
    endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Unsigned WIDTH x WIDTH multiplier with MULT_LAT-1 register levels in front
// of the consumer: captured operands, then product balancing stages.
// MULT_LAT=1 degenerates to a purely combinational product of the live inputs.
module alu_mult_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   prod_o
);

    if (MULT_LAT == 1) begin : g_comb
        logic unused_s;
        assign unused_s = ^{clk, rst_n, flush_i, load_i};
        assign prod_o   = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    end else begin : g_pipe
        logic [WIDTH-1:0]   a_q;
        logic [WIDTH-1:0]   b_q;
        logic [2*WIDTH-1:0] mult_s;

        // Operand capture on accepted MUL; flush clears so no stale product survives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= {WIDTH{1'b0}};
                b_q <= {WIDTH{1'b0}};
            end else if (flush_i) begin
                a_q <= {WIDTH{1'b0}};
                b_q <= {WIDTH{1'b0}};
            end else if (load_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end else begin
                a_q <= a_q;
                b_q <= b_q;
            end
        end

        assign mult_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        if (MULT_LAT == 2) begin : g_nostage
            assign prod_o = mult_s;
        end else begin : g_stages
            logic [2*WIDTH-1:0] stage_q [MULT_LAT-2];

            // Balancing shift register so the product arrives on the completion edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MULT_LAT - 2; i++) stage_q[i] <= {2*WIDTH{1'b0}};
                end else if (flush_i) begin
                    for (int i = 0; i < MULT_LAT - 2; i++) stage_q[i] <= {2*WIDTH{1'b0}};
                end else begin
                    stage_q[0] <= mult_s;
                    for (int i = 1; i < MULT_LAT - 2; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign prod_o = stage_q[MULT_LAT-3];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Parametrised ALU with ready/start/done handshake. ADD/AND/XOR/SUB complete
// in one cycle; MUL goes through alu_mult_pipe and holds the block busy until
// the product lands, unless aborted.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    input  logic                 abort,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Counter holds the busy edges remaining before the completion edge.
    localparam int   CW        = (MULT_LAT > 2) ? $clog2(MULT_LAT) : 1;
    localparam int   CNT_LOAD  = (MULT_LAT > 2) ? (MULT_LAT - 2) : 0;
    localparam logic MUL_MULTI = (MULT_LAT > 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    alu_op_e            op_s;
    logic               ready_s;
    logic               accept_s;
    logic               mul_multi_s;
    logic               flush_s;
    logic               load_s;
    logic [WIDTH:0]     sub_s;
    logic [2*WIDTH-1:0] alu_res_s;
    logic [2*WIDTH-1:0] mult_prod_s;

    assign op_s        = alu_op_e'(op);
    assign accept_s    = start && ready_s && is_valid_op(op);
    assign mul_multi_s = accept_s && (op_s == OP_MUL) && MUL_MULTI;
    assign load_s      = accept_s && (op_s == OP_MUL);
    assign flush_s     = (state_q == ST_MBUSY) && abort;
    // Extra top bit of the difference is exactly the borrow (A < B).
    assign sub_s       = {1'b0, A} - {1'b0, B};

    alu_mult_pipe #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk     (clk),
        .rst_n   (reset_n),
        .flush_i (flush_s),
        .load_i  (load_s),
        .a_i     (A),
        .b_i     (B),
        .prod_o  (mult_prod_s)
    );

    // Single-cycle datapath, zero-extended to the full result width.
    always_comb begin
        alu_res_s = {2*WIDTH{1'b0}};
        case (op_s)
            OP_ADD:  alu_res_s = {{WIDTH{1'b0}}, A} + {{WIDTH{1'b0}}, B};
            OP_AND:  alu_res_s = {{WIDTH{1'b0}}, A & B};
            OP_XOR:  alu_res_s = {{WIDTH{1'b0}}, A ^ B};
            OP_SUB:  alu_res_s = {{(WIDTH-1){1'b0}}, sub_s};
            OP_MUL:  alu_res_s = mult_prod_s;
            default: alu_res_s = {2*WIDTH{1'b0}};
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            done_q   <= 1'b0;
            result_q <= {2*WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state: enter MBUSY on a multi-cycle MUL, leave on abort or count expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_multi_s) begin
                    state_d = ST_MBUSY;
                    cnt_d   = CW'(CNT_LOAD);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            end
            ST_MBUSY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_MBUSY;
                    cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Outputs: ready decodes state; done/result next values for the registers.
    always_comb begin
        ready_s  = (state_q == ST_IDLE);
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !mul_multi_s) begin
                    done_d   = 1'b1;
                    result_d = alu_res_s;
                end else begin
                    done_d   = 1'b0;
                    result_d = result_q;
                end
            end
            ST_MBUSY: begin
                if (!abort && (cnt_q == {CW{1'b0}})) begin
                    done_d   = 1'b1;
                    result_d = mult_prod_s;
                end else begin
                    done_d   = 1'b0;
                    result_d = result_q;
                end
            end
            default: begin
                done_d   = 1'b0;
                result_d = result_q;
            end
        endcase
    end

    assign ready  = ready_s;
    assign done   = done_q;
    assign result = result_q;

endmodule
